// File: rtl/io_request_arbiter.sv
// Round-robin arbiter sharing the non-cached I/O bus among the cores' I/O request ports.
// A grant in cycle N drives the bus in N+1; read data is sampled at the end of N+2 and a
// tagged response (core, thread, value) is broadcast in N+3.
module io_request_arbiter #(
  parameter int unsigned NUM_REQUESTERS   = 4,
  parameter int unsigned THREADS_PER_CORE = 4,
  parameter int unsigned THREAD_IDX_WIDTH = $clog2(THREADS_PER_CORE)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQUESTERS-1:0]                  ioreq_valid,
  input  logic [NUM_REQUESTERS-1:0]                  ioreq_store,
  input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0] ioreq_thread_idx,
  input  logic [NUM_REQUESTERS*32-1:0]               ioreq_address,
  input  logic [NUM_REQUESTERS*32-1:0]               ioreq_value,
  output logic [NUM_REQUESTERS-1:0]                  ioreq_ack,
  output logic                                       io_write_en,
  output logic                                       io_read_en,
  output logic [31:0]                                io_address,
  output logic [31:0]                                io_write_data,
  input  logic [31:0]                                io_read_data,
  output logic                                       iorsp_valid,
  output logic [3:0]                                 iorsp_core,
  output logic [THREAD_IDX_WIDTH-1:0]                iorsp_thread_idx,
  output logic [31:0]                                iorsp_read_value
);

  localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  // Per-requester views of the flattened request buses.
  logic [THREAD_IDX_WIDTH-1:0] req_thread [NUM_REQUESTERS];
  logic [31:0]                 req_addr   [NUM_REQUESTERS];
  logic [31:0]                 req_data   [NUM_REQUESTERS];

  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_unpack
    assign req_thread[gi] = ioreq_thread_idx[gi*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
    assign req_addr[gi]   = ioreq_address[gi*32 +: 32];
    assign req_data[gi]   = ioreq_value[gi*32 +: 32];
  end

  logic [PTR_W-1:0] ptr, ptr_next;
  logic [4:0]       ptr_inc;
  logic [15:0]      valid_ext, ack_ext;
  logic [4:0]       scan_idx;
  logic             grant_any;
  logic [3:0]       grant_idx;

  logic                        sel_store;
  logic [THREAD_IDX_WIDTH-1:0] sel_thread;
  logic [31:0]                 sel_addr, sel_data;

  // Issue stage (bus cycle) and capture stage (read-data cycle) bookkeeping.
  logic                        iss_valid, cap_valid;
  logic                        iss_store, cap_store;
  logic [3:0]                  iss_core, cap_core;
  logic [THREAD_IDX_WIDTH-1:0] iss_thread, cap_thread;

  // Round-robin search upward from the priority pointer, wrapping at NUM_REQUESTERS.
  always_comb begin
    valid_ext = 16'(ioreq_valid);
    ack_ext   = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        scan_idx = 5'(ptr) + 5'(i);
        if (scan_idx >= 5'(NUM_REQUESTERS)) scan_idx = scan_idx - 5'(NUM_REQUESTERS);
        if (!grant_any && valid_ext[scan_idx[3:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx[3:0];
        end
      end
    end
    ack_ext[grant_idx] = grant_any;
  end

  assign ioreq_ack = ack_ext[NUM_REQUESTERS-1:0];

  // Mux out the granted request's fields.
  always_comb begin
    sel_store  = 1'b0;
    sel_thread = '0;
    sel_addr   = '0;
    sel_data   = '0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (grant_idx == 4'(j)) begin
        sel_store  = ioreq_store[j];
        sel_thread = req_thread[j];
        sel_addr   = req_addr[j];
        sel_data   = req_data[j];
      end
    end
  end

  // Pointer moves just past the winner; held when nothing is granted.
  always_comb begin
    ptr_inc = 5'(grant_idx) + 5'd1;
    if (ptr_inc >= 5'(NUM_REQUESTERS)) ptr_inc = '0;
    ptr_next = grant_any ? ptr_inc[PTR_W-1:0] : ptr;
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Bus outputs: strobes every cycle, address/data only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_write_en   <= 1'b0;
      io_read_en    <= 1'b0;
      io_address    <= '0;
      io_write_data <= '0;
    end else begin
      io_write_en <= grant_any & sel_store;
      io_read_en  <= grant_any & ~sel_store;
      if (grant_any) begin
        io_address    <= sel_addr;
        io_write_data <= sel_data;
      end
    end
  end

  // Tag pipeline: issue stage then capture stage, tracking the bus transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid  <= 1'b0;
      iss_store  <= 1'b0;
      iss_core   <= '0;
      iss_thread <= '0;
      cap_valid  <= 1'b0;
      cap_store  <= 1'b0;
      cap_core   <= '0;
      cap_thread <= '0;
    end else begin
      iss_valid  <= grant_any;
      iss_store  <= sel_store;
      iss_core   <= grant_idx;
      iss_thread <= sel_thread;
      cap_valid  <= iss_valid;
      cap_store  <= iss_store;
      cap_core   <= iss_core;
      cap_thread <= iss_thread;
    end
  end

  // Response: read data sampled in the capture cycle; stores answer with zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iorsp_valid      <= 1'b0;
      iorsp_core       <= '0;
      iorsp_thread_idx <= '0;
      iorsp_read_value <= '0;
    end else begin
      iorsp_valid      <= cap_valid;
      iorsp_core       <= cap_core;
      iorsp_thread_idx <= cap_thread;
      iorsp_read_value <= (cap_valid && !cap_store) ? io_read_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_io_request_arbiter.sv
// Bench for io_request_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-queue model of the arbiter.
module tb_io_request_arbiter;

  localparam int N  = 4;
  localparam int TW = 2;

  logic            clk, reset;
  logic [N-1:0]    valid, store;
  logic [TW-1:0]   thr  [N];
  logic [31:0]     addr [N];
  logic [31:0]     wdat [N];
  logic [N*TW-1:0] ioreq_thread_idx;
  logic [N*32-1:0] ioreq_address, ioreq_value;
  logic [N-1:0]    ioreq_ack;
  logic            io_write_en, io_read_en;
  logic [31:0]     io_address, io_write_data, io_read_data;
  logic            iorsp_valid;
  logic [3:0]      iorsp_core;
  logic [TW-1:0]   iorsp_thread_idx;
  logic [31:0]     iorsp_read_value;

  int checks = 0;
  int errors = 0;

  io_request_arbiter #(.NUM_REQUESTERS(N), .THREADS_PER_CORE(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .ioreq_valid      (valid),
    .ioreq_store      (store),
    .ioreq_thread_idx (ioreq_thread_idx),
    .ioreq_address    (ioreq_address),
    .ioreq_value      (ioreq_value),
    .ioreq_ack        (ioreq_ack),
    .io_write_en      (io_write_en),
    .io_read_en       (io_read_en),
    .io_address       (io_address),
    .io_write_data    (io_write_data),
    .io_read_data     (io_read_data),
    .iorsp_valid      (iorsp_valid),
    .iorsp_core       (iorsp_core),
    .iorsp_thread_idx (iorsp_thread_idx),
    .iorsp_read_value (iorsp_read_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    ioreq_thread_idx = '0;
    ioreq_address    = '0;
    ioreq_value      = '0;
    for (int i = 0; i < N; i++) begin
      ioreq_thread_idx[i*TW +: TW] = thr[i];
      ioreq_address[i*32 +: 32]    = addr[i];
      ioreq_value[i*32 +: 32]      = wdat[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          core;
    int          thread;
    bit          is_store;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    int          gcyc;
  } txn_t;

  txn_t        q[$];
  int          cyc = 0;
  int          mptr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;

  always @(negedge clk) begin
    int   g, idx;
    bit   we_e, re_e;
    txn_t t;
    if (reset) begin
      chk("rst_ack", 32'(ioreq_ack), 0);
      chk("rst_we", 32'(io_write_en), 0);
      chk("rst_re", 32'(io_read_en), 0);
      chk("rst_rsp_valid", 32'(iorsp_valid), 0);
      q.delete();
      mptr = 0;
      m_addr = 0;
      m_wdata = 0;
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        idx = (mptr + i) % N;
        if (g < 0 && valid[idx]) g = idx;
      end
      chk("ack", 32'(ioreq_ack), (g >= 0) ? (32'd1 << g) : 32'd0);
      we_e = 0;
      re_e = 0;
      foreach (q[k]) begin
        if (q[k].gcyc == cyc - 1) begin
          we_e = q[k].is_store;
          re_e = !q[k].is_store;
          m_addr = q[k].a;
          m_wdata = q[k].d;
        end
        if (q[k].gcyc == cyc - 2 && !q[k].is_store) q[k].rdata = io_read_data;
      end
      chk("bus_we", 32'(io_write_en), 32'(we_e));
      chk("bus_re", 32'(io_read_en), 32'(re_e));
      chk("bus_addr", io_address, m_addr);
      chk("bus_wdata", io_write_data, m_wdata);
      if (q.size() > 0 && q[0].gcyc == cyc - 3) begin
        t = q.pop_front();
        chk("rsp_valid", 32'(iorsp_valid), 1);
        chk("rsp_core", 32'(iorsp_core), 32'(t.core));
        chk("rsp_thread", 32'(iorsp_thread_idx), 32'(t.thread));
        chk("rsp_value", iorsp_read_value, t.is_store ? 32'h0 : t.rdata);
      end else begin
        chk("rsp_idle", 32'(iorsp_valid), 0);
      end
      if (g >= 0) begin
        t.core = g;
        t.thread = int'(thr[g]);
        t.is_store = store[g];
        t.a = addr[g];
        t.d = wdat[g];
        t.rdata = 0;
        t.gcyc = cyc;
        q.push_back(t);
        mptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] last_ack;

  initial begin
    reset = 1'b1;
    valid = '0;
    store = '0;
    io_read_data = '0;
    for (int i = 0; i < N; i++) begin
      thr[i] = '0;
      addr[i] = '0;
      wdat[i] = '0;
    end
    @(negedge clk);
    chk("reset_addr", io_address, 0);
    chk("reset_wdata", io_write_data, 0);
    chk("reset_rsp_core", 32'(iorsp_core), 0);
    chk("reset_rsp_value", iorsp_read_value, 0);

    // Reset in the capture cycle of a load drops it.
    cycle(); reset = 0;
    valid[0] = 1; store[0] = 0; addr[0] = 32'h20; thr[0] = 1;
    @(negedge clk); chk("mid_ack", 32'(ioreq_ack), 32'h1);
    cycle(); valid[0] = 0;
    @(negedge clk); chk("mid_re", 32'(io_read_en), 1);
    cycle(); reset = 1;
    @(negedge clk); chk("mid_rst_rsp", 32'(iorsp_valid), 0);
    cycle(); reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drop_rsp", 32'(iorsp_valid), 0);
      chk("drop_re", 32'(io_read_en), 0);
      cycle();
    end

    // Pointer back at 0: {0,3} grants 0 first, then the core 3 load.
    valid = 4'b1001; store = 0; addr[0] = 32'h80; addr[3] = 32'h100; thr[3] = 3;
    @(negedge clk); chk("ptr0_ack", 32'(ioreq_ack), 32'h1);
    cycle(); valid[0] = 0;
    @(negedge clk); chk("c3_ack", 32'(ioreq_ack), 32'h8);
    cycle(); valid[3] = 0;
    @(negedge clk); chk("c3_re", 32'(io_read_en), 1); chk("c3_addr", io_address, 32'h100);
    cycle(); io_read_data = 32'hDEAD_BEEF;
    @(negedge clk);
    cycle(); io_read_data = 32'h0;
    @(negedge clk);
    chk("c3_rsp_valid", 32'(iorsp_valid), 1);
    chk("c3_rsp_core", 32'(iorsp_core), 3);
    chk("c3_rsp_thread", 32'(iorsp_thread_idx), 3);
    chk("c3_rsp_value", iorsp_read_value, 32'hDEAD_BEEF);

    // Store from core 1, thread 2.
    cycle();
    valid[1] = 1; store[1] = 1; thr[1] = 2; addr[1] = 32'h40; wdat[1] = 32'h1234_5678;
    @(negedge clk); chk("st_ack", 32'(ioreq_ack), 32'h2);
    cycle(); valid[1] = 0;
    @(negedge clk);
    chk("st_we", 32'(io_write_en), 1);
    chk("st_re", 32'(io_read_en), 0);
    chk("st_wdata", io_write_data, 32'h1234_5678);
    cycle(); @(negedge clk);
    cycle(); @(negedge clk);
    chk("st_rsp_core", 32'(iorsp_core), 1);
    chk("st_rsp_thread", 32'(iorsp_thread_idx), 2);
    chk("st_rsp_value", iorsp_read_value, 0);

    // Round robin with all four holding valid for 8 cycles.
    cycle(); reset = 1;
    @(negedge clk);
    cycle(); reset = 0;
    for (int k = 0; k < 11; k++) begin
      cycle();
      if (k == 0) begin
        valid = 4'hF; store = 4'b0101;
        for (int i = 0; i < N; i++) begin
          addr[i] = 32'h200 + 32'(i * 4);
          wdat[i] = 32'hC0DE_0000 + 32'(i);
        end
      end
      if (k == 8) valid = 0;
      io_read_data = $urandom;
      @(negedge clk);
      if (k < 8) chk("rr_ack", 32'(ioreq_ack), 32'd1 << (k % 4));
      if (k >= 1 && k <= 8) chk("rr_one_op", 32'(io_read_en ^ io_write_en), 1);
      if (k >= 3) chk("rr_rsp_core", 32'(iorsp_core), 32'((k - 3) % 4));
    end

    // Wrap/skip: move pointer to 3, then {0,2} grants 0 then 2, pointer ends at 3.
    cycle(); valid = 4'b0100; store = 0;
    @(negedge clk); chk("wrap_c2", 32'(ioreq_ack), 32'h4);
    cycle(); valid = 4'b0101;
    @(negedge clk); chk("wrap_0", 32'(ioreq_ack), 32'h1);
    cycle(); valid = 4'b0100;
    @(negedge clk); chk("wrap_2", 32'(ioreq_ack), 32'h4);
    cycle(); valid = 4'b1001;
    @(negedge clk); chk("wrap_ptr3", 32'(ioreq_ack), 32'h8);
    cycle(); valid = 4'b0001;
    @(negedge clk); chk("wrap_after", 32'(ioreq_ack), 32'h1);
    cycle(); valid = 0;
    for (int k = 0; k < 3; k++) cycle();

    // Back-to-back load then store from core 2.
    valid = 4'b0100; store[2] = 0; addr[2] = 32'h10;
    @(negedge clk); chk("bb_ack_ld", 32'(ioreq_ack), 32'h4);
    cycle(); store[2] = 1; addr[2] = 32'h20; wdat[2] = 32'h55;
    @(negedge clk);
    chk("bb_ack_st", 32'(ioreq_ack), 32'h4);
    chk("bb_re", 32'(io_read_en), 1);
    chk("bb_we0", 32'(io_write_en), 0);
    cycle(); valid = 0; io_read_data = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("bb_we", 32'(io_write_en), 1);
    chk("bb_re0", 32'(io_read_en), 0);
    cycle(); io_read_data = 32'hFFFF_0000;
    @(negedge clk); chk("bb_rsp_ld", iorsp_read_value, 32'hA5A5_A5A5);
    cycle();
    @(negedge clk);
    chk("bb_rsp_st_valid", 32'(iorsp_valid), 1);
    chk("bb_rsp_st", iorsp_read_value, 0);

    // Idle after drain.
    for (int k = 0; k < 5; k++) begin
      cycle();
      @(negedge clk);
      chk("idle_ack", 32'(ioreq_ack), 0);
      chk("idle_bus", 32'({io_read_en, io_write_en}), 0);
      chk("idle_rsp", 32'(iorsp_valid), 0);
    end

    // Random traffic with occasional resets; requests hold until acked.
    last_ack = '0;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (reset) reset = 0;
      else if ($urandom_range(0, 149) == 0) reset = 1;
      for (int i = 0; i < N; i++) begin
        if (last_ack[i] || !valid[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            valid[i] = 1;
            store[i] = 1'($urandom_range(0, 1));
            thr[i]   = TW'($urandom_range(0, 3));
            addr[i]  = $urandom;
            wdat[i]  = $urandom;
          end else begin
            valid[i] = 0;
          end
        end
      end
      io_read_data = $urandom;
      @(negedge clk);
      last_ack = ioreq_ack;
    end

    cycle();
    reset = 0;
    valid = 0;
    for (int k = 0; k < 4; k++) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_request_arbiter.md
Name: io_request_arbiter

Overview:
Shares the single non-cached I/O bus (peripheral register master port) between the I/O request ports of all cores. The block arbitrates requests round-robin and drives the bus from registers. It captures read data on the bus's fixed one-cycle read latency and broadcasts a tagged response (core, thread, value) to all cores. It sits at the top level, between the per-core I/O request outputs and the io bus master.

Parameters:
NUM_REQUESTERS, 4, number of requesting cores; range 1..16, because the core id is 4 bits.
THREADS_PER_CORE, 4, threads per core; must be a power of two and at least 2.
THREAD_IDX_WIDTH, $clog2(THREADS_PER_CORE), derived; width of the thread index.

Ports:
clk  in  1  clock; all state is updated on the rising edge.
reset  in  1  asynchronous, active-high reset.
ioreq_valid  in  NUM_REQUESTERS  per-core request valid; held until acked.
ioreq_store  in  NUM_REQUESTERS  per-core: 1 = store, 0 = load.
ioreq_thread_idx  in  NUM_REQUESTERS*THREAD_IDX_WIDTH  per-core issuing thread.
ioreq_address  in  NUM_REQUESTERS*32  per-core address.
ioreq_value  in  NUM_REQUESTERS*32  per-core store data.
ioreq_ack  out  NUM_REQUESTERS  one-hot grant, combinational, in the grant cycle.
io_write_en  out  1  bus write strobe (registered).
io_read_en  out  1  bus read strobe (registered).
io_address  out  32  bus address (registered).
io_write_data  out  32  bus write data (registered).
io_read_data  in  32  bus read data; valid one cycle after io_read_en.
iorsp_valid  out  1  response valid, one-cycle pulse (registered).
iorsp_core  out  4  index of the requester being answered.
iorsp_thread_idx  out  THREAD_IDX_WIDTH  thread being answered.
iorsp_read_value  out  32  load data; 0 for stores.

Behaviour:
- Reset values: all outputs 0; priority pointer 0; all pipeline valid bits 0.
- Reset asserted mid-operation drops every in-flight transaction; no response is produced for it.
- Grant (cycle N):
  - Among requesters with ioreq_valid set, pick the first one searching upward from the priority pointer, wrapping modulo NUM_REQUESTERS.
  - Assert ioreq_ack[g] combinationally in cycle N.
  - Pointer becomes (g+1) mod NUM_REQUESTERS on the edge; it is unchanged if nothing was granted.
  - A requester sees ack at the edge and may present its next request in N+1.
  - No backpressure exists, so a grant is possible every cycle. Sustained throughput is 1 transaction/cycle.
- Issue (cycle N+1):
  - Registered bus outputs carry the granted request.
  - io_write_en = store, io_read_en = !store; the two are never both 1.
  - io_address and io_write_data are from the request.
  - With no grant in N, both enables are 0 in N+1; address and data hold their previous value.
- Capture (cycle N+2): a stage register holds core, thread, store and valid. io_read_data is sampled at the end of N+2.
- Response (cycle N+3):
  - iorsp_valid = 1 for one cycle, for both loads and stores.
  - iorsp_core = g, iorsp_thread_idx = the request's thread.
  - iorsp_read_value = the sampled data for a load, 32'h0 for a store.
  - Fixed latency: ack edge to response = 3 cycles.
- Ordering: responses are emitted in grant order; at most 3 transactions are in flight.
- Fairness: a requester holding valid is granted within NUM_REQUESTERS cycles.
- NUM_REQUESTERS = 1: the pointer is constant 0 and requester 0 is acked whenever it is valid.
- iorsp_core is zero-extended to 4 bits.

Test Plan:
- Reset mid-flight: assert reset at N+2 of a load -> iorsp_valid stays 0, bus enables 0, pointer 0. Then one load from core 3 (addr 32'h0000_0100) -> ack[3] at cycle N; io_read_en=1, io_address=32'h100 at N+1; drive io_read_data=32'hDEAD_BEEF at N+2 -> iorsp_valid=1, core=3, read_value=32'hDEADBEEF at N+3.
- Store: core 1, thread 2, addr 32'h0000_0040, value 32'h1234_5678 -> io_write_en=1, io_write_data=32'h12345678 at N+1 -> response core=1, thread=2, read_value=0 at N+3.
- Round-robin: cores 0..3 valid continuously for 8 cycles -> ack order 0,1,2,3,0,1,2,3; one bus op per cycle; 8 responses in the same order.
- Pointer wrap/skip: pointer=3, valid={core0,core2} -> grant 0 first, then 2; pointer ends at 3.
- Back-to-back mixed load/store from core 2 (load 32'h10 returns 32'hA5A5_A5A5, then store) -> io_read_en and io_write_en in consecutive cycles, never simultaneous; responses in order: 32'hA5A5A5A5, then 0.
- Idle: no valid for 5 cycles after traffic -> ioreq_ack=0, io_read_en=io_write_en=0, iorsp_valid=0 after drain.
